// File: rtl/sram22_mbist_pkg.sv
// Shared types and March C- element tables for the sram22 BIST controller.
// Each table is indexed by element number. Bit n describes element Mn.
package sram22_mbist_pkg;

    localparam int unsigned FAIL_CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    // Bit n of each table describes element Mn.
    localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
    localparam logic [7:0] ELEM_RD     = 8'b0011_1110;
    localparam logic [7:0] ELEM_WR     = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_VAL = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_VAL = 8'b0000_1010;
    localparam logic [7:0] ELEM_TWO_OP = ELEM_RD & ELEM_WR;

    function automatic logic elem_bit(input logic [7:0] tbl, input logic [2:0] elem);
        return tbl[elem];
    endfunction

endpackage

// File: rtl/sram22_mbist_cmp.sv
// One-stage read-compare pipeline with first-failure capture.
// A read issued in one cycle is compared against mem_dout_i at the following edge.
module sram22_mbist_cmp
    import sram22_mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rstb_i,
    input  logic                  clear_i,
    input  logic                  issue_rd_i,
    input  logic [DATA_WIDTH-1:0] exp_i,
    input  logic [2:0]            elem_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] mem_dout_i,
    output logic                  fail_o,
    output logic [2:0]            fail_elem_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [FAIL_CNT_W-1:0] fail_cnt_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [2:0]            elem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  fail_q;
    logic [2:0]            fail_elem_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q;
    logic [FAIL_CNT_W-1:0] fail_cnt_q;
    logic                  miscmp;

    assign miscmp = valid_q && (mem_dout_i != exp_q);

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            valid_q     <= 1'b0;
            exp_q       <= '0;
            elem_q      <= '0;
            addr_q      <= '0;
            fail_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_cnt_q  <= '0;
        end else if (clear_i) begin
            valid_q     <= 1'b0;
            fail_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            valid_q <= issue_rd_i;
            if (issue_rd_i) begin
                exp_q  <= exp_i;
                elem_q <= elem_i;
                addr_q <= addr_i;
            end
            if (miscmp) begin
                if (fail_cnt_q != '1) begin
                    fail_cnt_q <= fail_cnt_q + 1'b1;
                end
                // Only the first miscompare of a run is recorded.
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_elem_q <= elem_q;
                    fail_addr_q <= addr_q;
                    fail_data_q <= mem_dout_i;
                end
            end
        end
    end

    assign fail_o      = fail_q;
    assign fail_elem_o = fail_elem_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;
    assign fail_cnt_o  = fail_cnt_q;

endmodule

// File: rtl/sram22_mbist_ctrl.sv
// March C- BIST controller for one sram22 macro.
// The functional port passes through to the macro whenever no test is running.
module sram22_mbist_ctrl
    import sram22_mbist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rstb_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [2:0]            fail_elem_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [FAIL_CNT_W-1:0] fail_cnt_o,
    input  logic                  func_ce_i,
    input  logic                  func_we_i,
    input  logic [ADDR_WIDTH-1:0] func_addr_i,
    input  logic [DATA_WIDTH-1:0] func_din_i,
    output logic [DATA_WIDTH-1:0] func_dout_o,
    output logic                  mem_ce_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i
);

    state_e                state_q;
    logic [2:0]            elem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  phase_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  is_down;
    logic                  op_rd;
    logic                  last_phase;
    logic                  last_addr;
    logic [2:0]            elem_nxt;
    logic                  start_acc;
    logic                  issue_rd;
    logic [DATA_WIDTH-1:0] bist_din;
    logic [DATA_WIDTH-1:0] bist_exp;

    always_comb begin
        is_down    = elem_bit(ELEM_DOWN, elem_q);
        // Two-op elements read on phase 0 and write on phase 1.
        op_rd      = elem_bit(ELEM_RD, elem_q) && !phase_q;
        last_phase = !elem_bit(ELEM_TWO_OP, elem_q) || phase_q;
        last_addr  = is_down ? (addr_q == '0) : (addr_q == '1);
        elem_nxt   = elem_q + 3'd1;
        bist_din   = {DATA_WIDTH{elem_bit(ELEM_WR_VAL, elem_q)}};
        bist_exp   = {DATA_WIDTH{elem_bit(ELEM_RD_VAL, elem_q)}};
        start_acc  = start_i && ((state_q == StIdle) || (state_q == StDone));
        issue_rd   = (state_q == StRun) && op_rd;
    end

    always_comb begin
        mem_ce_o   = func_ce_i;
        mem_we_o   = func_we_i;
        mem_addr_o = func_addr_i;
        mem_din_o  = func_din_i;
        unique case (state_q)
            StRun: begin
                mem_ce_o   = 1'b1;
                mem_we_o   = !op_rd;
                mem_addr_o = addr_q;
                mem_din_o  = bist_din;
            end
            StFlush: begin
                mem_ce_o   = 1'b0;
                mem_we_o   = 1'b0;
                mem_addr_o = '0;
                mem_din_o  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q <= StIdle;
            elem_q  <= M0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_acc) begin
                        state_q <= StRun;
                        elem_q  <= M0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (!last_phase) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (!last_addr) begin
                            addr_q <= is_down ? addr_q - 1'b1 : addr_q + 1'b1;
                        end else if (elem_q == M5) begin
                            state_q <= StFlush;
                        end else begin
                            // Seamless hand-off: next element's first address, no idle cycle.
                            elem_q <= elem_nxt;
                            addr_q <= elem_bit(ELEM_DOWN, elem_nxt) ? '1 : '0;
                        end
                    end
                end
                StFlush: begin
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sram22_mbist_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cmp (
        .clk_i      (clk_i),
        .rstb_i     (rstb_i),
        .clear_i    (start_acc),
        .issue_rd_i (issue_rd),
        .exp_i      (bist_exp),
        .elem_i     (elem_q),
        .addr_i     (addr_q),
        .mem_dout_i (mem_dout_i),
        .fail_o     (fail_o),
        .fail_elem_o(fail_elem_o),
        .fail_addr_o(fail_addr_o),
        .fail_data_o(fail_data_o),
        .fail_cnt_o (fail_cnt_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign func_dout_o = mem_dout_i;

endmodule
